step_controller: RTL
====================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive clockIn cycles a changed stepButton level must persist before it is accepted (legal range 2..65535).
REQ-002 SHALL have port clockIn, input, 1, single fast system clock; all flops use its rising edge.
REQ-003 SHALL have port resetN, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port slowClock, input, 1, divided clock from the clock divider; treated as an asynchronous level.
REQ-005 SHALL have port runSwitch, input, 1, asynchronous level: 1 = free-run request, 0 = stop.
REQ-006 SHALL have port stepButton, input, 1, raw asynchronous pushbutton, active-high, bouncing.
REQ-007 SHALL have port haltReq, input, 1, synchronous to clockIn: the CPU executed a halt.
REQ-008 SHALL have port cpuEnable, output, 1, registered one-cycle pulse; the CPU advances one cycle per pulse.
REQ-009 SHALL have port running, output, 1, registered; high exactly while the FSM is in RUN.
REQ-010 SHALL have port stepCount, output, 16, count of cpuEnable pulses issued.

Function
REQ-011 SHALL pass slowClock, runSwitch and stepButton each through a 2-flop synchronizer.
REQ-012 SHALL generate slowTick = synchronized slowClock high AND its one-cycle-delayed copy low, giving exactly one clockIn cycle per slowClock rising edge.
REQ-013 SHALL have this latency: when slowClock is first sampled high at edge k, a qualified cpuEnable is high in the cycle after edge k+2.
REQ-014 SHALL debounce stepButton as follows: the counter increments while the synchronized level differs from the stable level and clears when they match; at DEBOUNCE_CYCLES-1 the stable level updates and the counter clears.
REQ-015 SHALL generate stepPress as a one-cycle pulse on each 0->1 transition of the debounced stable level.
REQ-016 SHALL implement FSM states STOP, RUN, STEP and HALT, and SHALL enter STOP on reset.
REQ-017 SHALL, in STOP, move to RUN if synchronized runSwitch=1; otherwise move to STEP on stepPress; otherwise stay in STOP. No enables are issued in STOP.
REQ-018 SHALL, in RUN, issue cpuEnable on every slowTick; if runSwitch=0, move to STOP; if haltReq=1, move to HALT.
REQ-019 SHALL, in STEP, issue exactly one cpuEnable on the next slowTick and then move to STOP; if haltReq=1, move to HALT.
REQ-020 SHALL, in HALT, issue no enables and move to STOP only when runSwitch=0 and the debounced button level is 0.
REQ-021 SHALL resolve simultaneous events as follows: haltReq beats slowTick (no enable is issued, next state is HALT); in STOP, runSwitch=1 beats stepPress (the press is dropped); in RUN, runSwitch=0 coinciding with slowTick issues no enable.
REQ-022 SHALL ignore stepPress in RUN, STEP and HALT; presses are never queued.
REQ-023 SHALL increment stepCount by 1 in the same cycle cpuEnable is high, wrapping 16'hFFFF -> 16'h0000.
REQ-024 SHALL keep cpuEnable high for at most one cycle per slowTick and never in two consecutive cycles.

Reset
REQ-025 SHALL, while resetN=0, asynchronously clear cpuEnable=0, running=0, stepCount=0, state=STOP, all synchronizer and edge flops=0, debounced stable level=0 and the debounce counter=0.
REQ-026 SHALL assert no cpuEnable within the first 3 clockIn cycles after resetN deassertion, regardless of input levels.
REQ-027 SHALL, on reset asserted mid-pulse, drop cpuEnable immediately without waiting for a clock edge.

Structure
REQ-028 SHALL place the 2-bit state encoding (STOP=0, RUN=1, STEP=2, HALT=3) and the debounce counter width constant (16) in shared package step_ctrl_pkg.
REQ-029 SHALL implement stepButton synchronization and debouncing in a single sub-module, button_debouncer, parameterized by DEBOUNCE_CYCLES and outputting the stable level and stepPress.
REQ-030 SHALL keep the FSM, the slowClock edge detector and stepCount in the top module.

Verification (DEBOUNCE_CYCLES=4, slowClock = clockIn/8)
REQ-031 SHALL verify free-run: runSwitch=1 for 64 clockIn cycles -> running=1 and 8 cpuEnable pulses, each 1 cycle wide and 8 cycles apart; stepCount=8.
REQ-032 SHALL verify single step: runSwitch=0 with a clean 10-cycle stepButton press -> exactly 1 cpuEnable, on the first slowTick after stepPress; stepCount 0->1; state returns to STOP.
REQ-033 SHALL verify bounce rejection: stepButton toggled every 2 cycles for 20 cycles, then held high -> exactly one stepPress and one cpuEnable.
REQ-034 SHALL verify halt priority: in RUN, haltReq=1 coincident with slowTick -> no cpuEnable, state=HALT; runSwitch=0 with button released -> state=STOP.
REQ-035 SHALL verify wrap: stepCount preloaded by running 65535 pulses, plus one more pulse -> stepCount=16'h0000.
REQ-036 SHALL verify mid-operation reset: resetN pulled low during a cpuEnable pulse -> cpuEnable=0 immediately; no cpuEnable for 3 cycles after release with slowClock=1 and runSwitch=1.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step controller: FSM state encoding and
// the width of the button debounce counter.
package step_ctrl_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } ctrlState_t;

   localparam int unsigned DEBOUNCE_WIDTH = 16;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the raw step pushbutton, filters contact bounce and emits
// a one-cycle stepPress on each accepted press (stable 0->1 transition).
module button_debouncer
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
)
(
   input  logic clockIn,
   input  logic resetN,
   input  logic buttonRaw,
   output logic stableLevel,
   output logic stepPress
);

   localparam logic [DEBOUNCE_WIDTH-1:0] COUNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                      buttonMeta;
   logic                      buttonSync;
   logic [DEBOUNCE_WIDTH-1:0] debounceCount;

   // Two-flop synchronizer for the asynchronous button level
   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         buttonMeta <= 1'b0;
         buttonSync <= 1'b0;
      end else begin
         buttonMeta <= buttonRaw;
         buttonSync <= buttonMeta;
      end
   end

   // Accept a new level only after it persists DEBOUNCE_CYCLES cycles; pulse on accepted rise
   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         stableLevel   <= 1'b0;
         debounceCount <= '0;
         stepPress     <= 1'b0;
      end else begin
         stepPress <= 1'b0;
         if (buttonSync != stableLevel) begin
            if (debounceCount == COUNT_LAST) begin
               stableLevel   <= buttonSync;
               debounceCount <= '0;
               stepPress     <= buttonSync;
            end else begin
               debounceCount <= debounceCount + DEBOUNCE_WIDTH'(1);
            end
         end else begin
            debounceCount <= '0;
         end
      end
   end

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable controller: free-run, single-step and halt handling.
// Issues one-cycle cpuEnable pulses aligned to rising edges of slowClock
// and counts them in stepCount.
module step_controller
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
)
(
   input  logic        clockIn,
   input  logic        resetN,
   input  logic        slowClock,
   input  logic        runSwitch,
   input  logic        stepButton,
   input  logic        haltReq,
   output logic        cpuEnable,
   output logic        running,
   output logic [15:0] stepCount
);

   logic       slowMeta;
   logic       slowSync;
   logic       slowDly;
   logic       slowTick;
   logic       runMeta;
   logic       runSync;
   logic       buttonLevel;
   logic       stepPress;
   logic       enableNext;
   ctrlState_t state;
   ctrlState_t stateNext;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clockIn    (clockIn),
      .resetN     (resetN),
      .buttonRaw  (stepButton),
      .stableLevel(buttonLevel),
      .stepPress  (stepPress)
   );

   // Synchronize slowClock and runSwitch; keep a delayed slowClock copy for edge detection
   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         slowMeta <= 1'b0;
         slowSync <= 1'b0;
         slowDly  <= 1'b0;
         runMeta  <= 1'b0;
         runSync  <= 1'b0;
      end else begin
         slowMeta <= slowClock;
         slowSync <= slowMeta;
         slowDly  <= slowSync;
         runMeta  <= runSwitch;
         runSync  <= runMeta;
      end
   end

   // One clockIn cycle per slowClock rising edge
   always_comb begin
      slowTick = slowSync & ~slowDly;
   end

   // Next state and enable decision; haltReq outranks any tick, stop request outranks a run tick
   always_comb begin
      stateNext  = state;
      enableNext = 1'b0;
      case (state)
         STOP: begin
            if (runSync) begin
               stateNext = RUN;
            end else if (stepPress) begin
               stateNext = STEP;
            end
         end
         RUN: begin
            if (haltReq) begin
               stateNext = HALT;
            end else if (!runSync) begin
               stateNext = STOP;
            end else if (slowTick) begin
               enableNext = 1'b1;
            end
         end
         STEP: begin
            if (haltReq) begin
               stateNext = HALT;
            end else if (slowTick) begin
               enableNext = 1'b1;
               stateNext  = STOP;
            end
         end
         HALT: begin
            if (!runSync && !buttonLevel) begin
               stateNext = STOP;
            end
         end
         default: stateNext = STOP;
      endcase
   end

   // State, registered outputs and the pulse counter
   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         state     <= STOP;
         cpuEnable <= 1'b0;
         running   <= 1'b0;
         stepCount <= '0;
      end else begin
         state     <= stateNext;
         cpuEnable <= enableNext;
         running   <= (stateNext == RUN);
         if (enableNext) begin
            stepCount <= stepCount + 16'd1;
         end
      end
   end

endmodule
